// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encoding, counter width, op classes.
// MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU ops to the multiply class.
`timescale 1ns/1ps
package mdu_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MADD  = 4'd7;
    localparam logic [3:0] MD_MADDU = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;
    localparam logic [3:0] MD_MSUBU = 4'd10;

    localparam int unsigned MD_CNT_W = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    function automatic logic MD_IS_MULT(input logic [3:0] op);
        logic r;
        r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
        r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
        return r;
    endfunction

    function automatic logic MD_IS_DIV(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// Decoded-op and HI/LO read bus between the E stage and the multiply/divide unit.
`timescale 1ns/1ps
interface e_mdu_if;
    import mdu_pkg::*;

    // start is the accept strobe: a MULT/DIV-class op is taken exactly in a cycle
    // where start=1; MTHI/MTLO are taken whenever busy=0; all else is dropped.
    logic [3:0]  md_op;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        hilo_sel;
    logic        busy;
    logic        start;
    logic [31:0] rd_data;
    md_state_t   state;

    modport master (
        output md_op, md_a, md_b, hilo_sel,
        input  busy, start, rd_data, state
    );

    modport slave (
        input  md_op, md_a, md_b, hilo_sel,
        output busy, start, rd_data, state
    );

endinterface

// File: rtl/e_mdu_arith.sv
// Combinational 64-bit result generator for multiply/divide ops, plus divide-by-zero flag.
// MDU_MADD_EN adds the accumulate/subtract datapath; otherwise ops 7-10 fall to the default.
`timescale 1ns/1ps
module e_mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  md_op,
    input  logic [31:0] md_a,
    input  logic [31:0] md_b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result,
    output logic        div_zero
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] div_n;
    logic [31:0] div_d;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic        is_signed_div;

    assign a_ext  = {{32{md_a[31]}}, md_a};
    assign b_ext  = {{32{md_b[31]}}, md_b};
    assign prod_s = a_ext * b_ext;
    assign prod_u = {32'd0, md_a} * {32'd0, md_b};

    assign div_zero = MD_IS_DIV(md_op) && (md_b == 32'd0);

    // One shared unsigned divider; signed division runs on magnitudes and
    // fixes signs afterwards (quotient toward zero, remainder follows dividend).
    assign b_safe        = (md_b == 32'd0) ? 32'd1 : md_b;
    assign is_signed_div = (md_op == MD_DIV);
    assign a_mag         = md_a[31] ? (32'd0 - md_a) : md_a;
    assign b_mag         = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign div_n         = is_signed_div ? a_mag : md_a;
    assign div_d         = is_signed_div ? b_mag : b_safe;
    assign quo           = div_n / div_d;
    assign rem           = div_n % div_d;
    assign quo_s         = (md_a[31] ^ md_b[31]) ? (32'd0 - quo) : quo;
    assign rem_s         = md_a[31] ? (32'd0 - rem) : rem;

    always_comb begin
        result = {hi, lo};
        case (md_op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quo_s};
            MD_DIVU:  result = {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
            MD_MSUB:  result = {hi, lo} - prod_s;
            MD_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: latency counter, busy flag and architectural HI/LO.
// MDU_MADD_EN enables the multiply-accumulate ops (7-10).
`timescale 1ns/1ps
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   md
);

    localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

    md_state_t             state;
    md_state_t             state_n;
    logic [MD_CNT_W-1:0]   cnt;
    logic [MD_CNT_W-1:0]   cnt_n;
    logic [31:0]           hi;
    logic [31:0]           lo;
    logic [63:0]           pending;
    logic                  pend_dz;
    logic [63:0]           arith_res;
    logic                  arith_dz;
    logic                  is_mult;
    logic                  is_div;
    logic                  busy;
    logic                  issue;
    logic                  commit;

    e_mdu_arith u_arith (
        .md_op    (md.md_op),
        .md_a     (md.md_a),
        .md_b     (md.md_b),
        .hi       (hi),
        .lo       (lo),
        .result   (arith_res),
        .div_zero (arith_dz)
    );

    assign is_mult = MD_IS_MULT(md.md_op);
    assign is_div  = MD_IS_DIV(md.md_op);
    assign busy    = (state == ST_BUSY);
    assign issue   = (is_mult || is_div) && !busy;

    assign md.busy    = busy;
    assign md.start   = issue;
    assign md.state   = state;
    assign md.rd_data = md.hilo_sel ? lo : hi;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        commit  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (issue) begin
                    state_n = ST_BUSY;
                    cnt_n   = is_div ? DIV_LD : MULT_LD;
                end
            end
            ST_BUSY: begin
                if (cnt == MD_CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - MD_CNT_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Divide-by-zero still consumes the full latency; only the HI/LO write is suppressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi      <= '0;
            lo      <= '0;
            pending <= '0;
            pend_dz <= 1'b0;
        end else begin
            if (issue) begin
                pending <= arith_res;
                pend_dz <= arith_dz;
            end
            if (commit) begin
                if (!pend_dz) begin
                    hi <= pending[63:32];
                    lo <= pending[31:0];
                end
            end else if (!busy && (md.md_op == MD_MTHI)) begin
                hi <= md.md_a;
            end else if (!busy && (md.md_op == MD_MTLO)) begin
                lo <= md.md_a;
            end
        end
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Execute-stage multiply/divide unit with architectural HI/LO registers.
- Consumes RD1_E/RD2_E and the decoded op from the D_E pipeline register.
- Models multi-cycle latency; exports a busy flag so the hazard unit stalls D and flushes E for dependent MD instructions.
- Provides HI/LO read data to the E-stage result mux for mfhi/mflo.

Parameters:
- MULT_CYCLES, 5: cycles from start to HI/LO commit for multiply-class ops (legal range 1-31).
- DIV_CYCLES, 10: cycles from start to HI/LO commit for divide ops (legal range 1-31).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- md_op  input  4  operation code. 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU; 11-15 treated as NONE.
- md_a  input  32  rs operand (RD1_E after forwarding).
- md_b  input  32  rt operand (RD2_E after forwarding).
- hilo_sel  input  1  0 selects HI, 1 selects LO on rd_data.
- busy  output  1  high while an operation is in flight.
- start  output  1  combinational: md_op is a MULT/DIV-class op this cycle and busy is low.
- rd_data  output  32  combinational HI or LO, per hilo_sel.

Behaviour:
- Reset (reset = 0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending result=0. Reset mid-operation drops the operation; no commit occurs.
- Idle and MULT-class op:
  - Compute the 64-bit result combinationally and capture it into the pending register.
  - Load the counter with MULT_CYCLES; busy=1 from the next cycle.
- Idle and DIV-class op: same flow, counter loaded with DIV_CYCLES.
- Each busy cycle the counter decrements. When it reaches 1, the next edge writes pending to {HI,LO}, clears busy and zeroes the counter.
- Net effect: an op issued at edge N commits at edge N+CYCLES. busy is high for exactly CYCLES cycles.
- MULT/MULTU: {HI,LO} = signed or unsigned 32x32 -> 64-bit product.
- DIV/DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divisor 0: the op runs its full latency, then HI and LO are left unchanged.
- MTHI/MTLO:
  - Accepted only when busy=0. Writes md_a to HI or LO at the next edge, with no busy period.
  - Ignored when busy=1, because the hazard unit guarantees a stall.
- Any op arriving while busy=1 is ignored. In-flight state is unaffected.
- A flush of the E stage does not cancel an operation that has already started.
- rd_data always reflects committed HI/LO, never pending values.
- mfhi/mflo dependency is enforced externally: the stall condition is start | busy.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 7-10 are legal.
  - Result = {HI,LO} +/- (signed or unsigned product of md_a, md_b), mod 2^64.
  - The accumulate base is the HI/LO value at issue time.
  - Latency MULT_CYCLES; start asserts for these ops.
- Undefined: ops 7-10 decode as NONE. start stays low, and no adder or subtractor is synthesized.

Decomposition:
- Shared package mdu_pkg holds:
  - md_op encoding localparams (MD_NONE..MD_MSUBU);
  - the width constant for the counter (5 bits);
  - the MD_IS_MULT/MD_IS_DIV classification helpers.
- One sub-module, e_mdu_arith: combinational 64-bit result generation from md_op, md_a, md_b, HI, LO. It also flags divide-by-zero.
- e_mdu itself keeps the counter, busy and HI/LO registers.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 -> start=1 for 1 cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV -7 / 2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0. DIVU 5 / 0 -> HI/LO keep prior values.
- MTHI 0x12345678 while idle -> HI=0x12345678 next edge, busy stays 0. MTLO issued during a DIV busy window -> ignored; LO equals the DIV result.
- Second MULT issued on the cycle after start -> ignored; the first result commits unchanged at N+5.
- Assert reset low at busy cycle 3 of a MULT -> immediately busy=0, HI=LO=0; no later commit.
- MDU_MADD_EN defined, HI=0, LO=0xFFFFFFFF, MADDU 1 x 1 -> HI=1, LO=0 after 5 cycles. Undefined: same op -> start=0, HI/LO unchanged.
